booth_multiplier: RTL and testbench

- Sequential signed radix-2 Booth multiplier: WIDTH×WIDTH two's-complement operands → 2·WIDTH-bit exact product.
- Used by the position/velocity integrators as a shared arithmetic primitive, e.g. dt × acceleration with default 16 → 32 bits.
- Controlled by a level start (en) and a busy flag. The controller raises en, waits for busy high, drops en, waits for busy low, then reads R.

---
 rtl/booth_mult_pkg.sv | 47 ++++
 rtl/booth_multiplier_step.sv | 37 +++
 rtl/booth_multiplier.sv | 122 ++++++++++++
 tb/tb_booth_multiplier.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// BOOTH_MULT_RADIX4_EN selects radix-4 recoding (2-bit shift per step) instead of radix-2.
package booth_mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

`ifdef BOOTH_MULT_RADIX4_EN
  localparam int RADIX_SHIFT = 2;
`else
  localparam int RADIX_SHIFT = 1;
`endif

  // Number of multiplier bits inspected per step (incl. the appended/previous bit)
  localparam int RECODE_W = RADIX_SHIFT + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    ADD  = 3'd1,
    SUB  = 3'd2,
    ADD2 = 3'd3,
    SUB2 = 3'd4
  } sel_e;

  function automatic sel_e booth_recode(input logic [RECODE_W-1:0] bits);
    sel_e sel;
    case (bits)
`ifdef BOOTH_MULT_RADIX4_EN
      3'b001, 3'b010: sel = ADD;
      3'b011:         sel = ADD2;
      3'b100:         sel = SUB2;
      3'b101, 3'b110: sel = SUB;
`else
      2'b01:          sel = ADD;
      2'b10:          sel = SUB;
`endif
      default:        sel = NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_multiplier_step.sv
// One combinational Booth step: add/subtract the selected multiple of mcand, then shift.
// Shift amount follows BOOTH_MULT_RADIX4_EN through booth_mult_pkg::RADIX_SHIFT.
module booth_step
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ACC_W = DEFAULT_WIDTH + RADIX_SHIFT
) (
  input  logic [ACC_W-1:0]     acc,
  input  logic [WIDTH:0]       mplier,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [2:0]           sel,
  output logic [ACC_W+WIDTH:0] nxt
);

  logic [ACC_W-1:0]            m1_s;
  logic [ACC_W-1:0]            m2_s;
  logic [ACC_W-1:0]            sum_s;
  logic signed [ACC_W+WIDTH:0] comb_s;

  // Partial-product add/sub followed by arithmetic shift of {acc, mplier}
  always_comb begin
    m1_s = {{(ACC_W-WIDTH){mcand[WIDTH-1]}}, mcand};
    m2_s = {m1_s[ACC_W-2:0], 1'b0};
    case (sel)
      ADD:     sum_s = acc + m1_s;
      SUB:     sum_s = acc - m1_s;
      ADD2:    sum_s = acc + m2_s;
      SUB2:    sum_s = acc - m2_s;
      NONE:    sum_s = acc;
      default: sum_s = acc;
    endcase
    comb_s = {sum_s, mplier};
    nxt    = comb_s >>> RADIX_SHIFT;
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, en/busy handshake.
// BOOTH_MULT_RADIX4_EN halves the CALC phase to WIDTH/2 cycles with identical results.
module booth_multiplier
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   R
);

  // Accumulator carries RADIX_SHIFT guard bits so +-2*mcand never overflows
  localparam int ACC_W = WIDTH + RADIX_SHIFT;
  localparam int STEPS = WIDTH / RADIX_SHIFT;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  state_e               state_r, state_nxt_s;
  logic [ACC_W-1:0]     acc_r, acc_nxt_s;
  logic [WIDTH:0]       mplier_r, mplier_nxt_s;
  logic [WIDTH-1:0]     mcand_r, mcand_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic [2*WIDTH-1:0]   r_r, r_nxt_s;
  sel_e                 sel_s;
  logic [ACC_W+WIDTH:0] step_s;

  assign sel_s = booth_recode(mplier_r[RECODE_W-1:0]);

  booth_step #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_step (
    .acc    (acc_r),
    .mplier (mplier_r),
    .mcand  (mcand_r),
    .sel    (sel_s),
    .nxt    (step_s)
  );

  // Next-state and datapath update logic
  always_comb begin
    state_nxt_s  = state_r;
    acc_nxt_s    = acc_r;
    mplier_nxt_s = mplier_r;
    mcand_nxt_s  = mcand_r;
    cnt_nxt_s    = cnt_r;
    busy_nxt_s   = busy_r;
    r_nxt_s      = r_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_nxt_s  = CALC;
          acc_nxt_s    = '0;
          mcand_nxt_s  = A;
          mplier_nxt_s = {B, 1'b0};
          cnt_nxt_s    = '0;
          busy_nxt_s   = 1'b1;
        end else begin
          state_nxt_s  = IDLE;
          busy_nxt_s   = 1'b0;
        end
      end
      CALC: begin
        acc_nxt_s    = step_s[ACC_W+WIDTH:WIDTH+1];
        mplier_nxt_s = step_s[WIDTH:0];
        cnt_nxt_s    = cnt_r + CNT_W'(1);
        // Product is the low 2*WIDTH bits of {acc, mplier} once the appended bit drops
        if (cnt_r == LAST_CNT) begin
          r_nxt_s     = step_s[2*WIDTH:1];
          busy_nxt_s  = 1'b0;
          state_nxt_s = DONE;
        end else begin
          busy_nxt_s  = 1'b1;
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        busy_nxt_s = 1'b0;
        if (en) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      acc_r    <= '0;
      mplier_r <= '0;
      mcand_r  <= '0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      r_r      <= '0;
    end else begin
      state_r  <= state_nxt_s;
      acc_r    <= acc_nxt_s;
      mplier_r <= mplier_nxt_s;
      mcand_r  <= mcand_nxt_s;
      cnt_r    <= cnt_nxt_s;
      busy_r   <= busy_nxt_s;
      r_r      <= r_nxt_s;
    end
  end

  assign busy = busy_r;
  assign R    = r_r;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and random self-checking bench for booth_multiplier (WIDTH=16).
// Expected busy length follows BOOTH_MULT_RADIX4_EN.
module tb_booth_multiplier;

  localparam int W = 16;
`ifdef BOOTH_MULT_RADIX4_EN
  localparam int EXP_BUSY = 8;
`else
  localparam int EXP_BUSY = 16;
`endif

  localparam int NV = 10;
  localparam logic [15:0] VA [0:NV-1] = '{16'h0003, 16'hFFFD, 16'hFFFD, 16'h8000, 16'h7FFF,
                                          16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h1234};
  localparam logic [15:0] VB [0:NV-1] = '{16'h0005, 16'h0005, 16'hFFFB, 16'h8000, 16'h8000,
                                          16'h1234, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h5678};
  localparam logic [31:0] VR [0:NV-1] = '{32'h0000_000F, 32'hFFFF_FFF1, 32'h0000_000F,
                                          32'h4000_0000, 32'hC000_8000, 32'h0000_0000,
                                          32'h3FFF_0001, 32'h0000_0001, 32'hFFFF_8000,
                                          32'h0626_0060};

  logic          clk;
  logic          rst;
  logic          en;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          busy;
  logic [2*W-1:0] R;

  int checks = 0;
  int errors = 0;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .A    (A),
    .B    (B),
    .busy (busy),
    .R    (R)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Start an operation, optionally drop en once busy is seen, count busy cycles.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit drop_en,
                        output int rise, output int ncyc, output bit tmo);
    @(negedge clk);
    A = a;
    B = b;
    en = 1'b1;
    rise = 0;
    ncyc = 0;
    tmo = 1'b0;
    while (!busy && rise < 4) begin
      @(negedge clk);
      rise++;
    end
    if (!busy) tmo = 1'b1;
    if (drop_en) en = 1'b0;
    while (busy && ncyc < 100) begin
      ncyc++;
      @(negedge clk);
    end
    if (busy) tmo = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    en = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (R !== 32'h0) begin errors++; $display("FAIL reset_R got %h want 00000000", R); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic;
    int rise, ncyc;
    bit tmo;
    run_op(16'd3, 16'd5, 1'b1, rise, ncyc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL basic_timeout got timeout want completion"); end
    checks++;
    if (rise != 1) begin errors++; $display("FAIL basic_rise got %0d want 1", rise); end
    checks++;
    if (ncyc != EXP_BUSY) begin errors++; $display("FAIL basic_busy_len got %0d want %0d", ncyc, EXP_BUSY); end
    checks++;
    if (R !== 32'h0000_000F) begin errors++; $display("FAIL basic_R got %h want 0000000f", R); end
  endtask

  task automatic test_vectors;
    int rise, ncyc;
    bit tmo;
    for (int i = 0; i < NV; i++) begin
      run_op(VA[i], VB[i], 1'b1, rise, ncyc, tmo);
      checks++;
      if (tmo || ncyc != EXP_BUSY) begin
        errors++;
        $display("FAIL vec%0d_busy_len got %0d want %0d", i, ncyc, EXP_BUSY);
      end
      checks++;
      if (R !== VR[i]) begin
        errors++;
        $display("FAIL vec%0d_R A=%h B=%h got %h want %h", i, VA[i], VB[i], R, VR[i]);
      end
    end
  endtask

  task automatic test_held_en;
    int rise, ncyc;
    bit tmo;
    bit stayed;
    run_op(16'd6, 16'd7, 1'b0, rise, ncyc, tmo);
    checks++;
    if (tmo || R !== 32'h0000_002A) begin errors++; $display("FAIL held_R got %h want 0000002a", R); end
    stayed = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0) stayed = 1'b0;
    end
    checks++;
    if (!stayed) begin errors++; $display("FAIL held_retrigger got busy want no restart"); end
    checks++;
    if (R !== 32'h0000_002A) begin errors++; $display("FAIL held_R_hold got %h want 0000002a", R); end
    en = 1'b0;
    run_op(16'd2, 16'd3, 1'b1, rise, ncyc, tmo);
    checks++;
    if (tmo || ncyc != EXP_BUSY) begin errors++; $display("FAIL rearm_busy_len got %0d want %0d", ncyc, EXP_BUSY); end
    checks++;
    if (R !== 32'h0000_0006) begin errors++; $display("FAIL rearm_R got %h want 00000006", R); end
  endtask

  task automatic test_operand_change;
    int n;
    @(negedge clk);
    A = 16'd9;
    B = 16'hFFF9;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL chg_busy got %b want 1", busy); end
    checks++;
    if (R !== 32'h0000_0006) begin errors++; $display("FAIL chg_R_hold got %h want 00000006", R); end
    en = 1'b0;
    A = 16'h1111;
    B = 16'h2222;
    @(negedge clk);
    en = 1'b1;
    A = 16'h7FFF;
    @(negedge clk);
    en = 1'b0;
    B = 16'h8000;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL chg_timeout got busy want idle"); end
    checks++;
    if (R !== 32'hFFFF_FFC1) begin errors++; $display("FAIL chg_R got %h want ffffffc1", R); end
  endtask

  task automatic test_reset_mid;
    int rise, ncyc;
    bit tmo;
    @(negedge clk);
    A = 16'd100;
    B = 16'd200;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", busy); end
    checks++;
    if (R !== 32'h0) begin errors++; $display("FAIL mid_reset_R got %h want 00000000", R); end
    @(negedge clk);
    rst = 1'b1;
    run_op(16'd100, 16'd200, 1'b1, rise, ncyc, tmo);
    checks++;
    if (tmo || ncyc != EXP_BUSY) begin errors++; $display("FAIL mid_after_busy_len got %0d want %0d", ncyc, EXP_BUSY); end
    checks++;
    if (R !== 32'h0000_4E20) begin errors++; $display("FAIL mid_after_R got %h want 00004e20", R); end
  endtask

  task automatic test_random;
    int rise, ncyc;
    bit tmo;
    logic signed [15:0] ra, rb;
    logic signed [31:0] rexp;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rexp = ra * rb;
      run_op(ra, rb, 1'b1, rise, ncyc, tmo);
      checks++;
      if (tmo || ncyc != EXP_BUSY) begin
        errors++;
        $display("FAIL rand%0d_busy_len got %0d want %0d", i, ncyc, EXP_BUSY);
      end
      checks++;
      if (R !== rexp) begin
        errors++;
        $display("FAIL rand%0d_R A=%h B=%h got %h want %h", i, ra, rb, R, rexp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_held_en;
    test_operand_change;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
